// File: rtl/pipe_pkg.sv
// Shared pipeline constants and F/D payload layout.
// Stages pack/unpack their bundles here; pipe_stage_reg stays field-agnostic.
package pipe_pkg;

  localparam int OPCODE_W = 5;
  localparam int REG_W    = 3;
  localparam int SHMNT_W  = 5;
  localparam int ADDR_W   = 32;

  localparam int FD_PAYLOAD_W = 80;

  localparam int FD_NEXT_LSB  = 0;
  localparam int FD_NEXT_MSB  = 31;
  localparam int FD_OPC_LSB   = 32;
  localparam int FD_OPC_MSB   = 36;
  localparam int FD_RS_LSB    = 37;
  localparam int FD_RS_MSB    = 39;
  localparam int FD_RD_LSB    = 40;
  localparam int FD_RD_MSB    = 42;
  localparam int FD_SHMNT_LSB = 43;
  localparam int FD_SHMNT_MSB = 47;
  localparam int FD_PC_LSB    = 48;
  localparam int FD_PC_MSB    = 79;

  localparam logic [OPCODE_W-1:0] NOP_OPCODE = '0;

  typedef struct packed {
    logic [ADDR_W-1:0]   pc;
    logic [SHMNT_W-1:0]  shmnt;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs;
    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0]   next_addr;
  } if_id_t;

  function automatic logic [FD_PAYLOAD_W-1:0] fd_pack(
    input logic [ADDR_W-1:0]   pc,
    input logic [SHMNT_W-1:0]  shmnt,
    input logic [REG_W-1:0]    rd,
    input logic [REG_W-1:0]    rs,
    input logic [OPCODE_W-1:0] opcode,
    input logic [ADDR_W-1:0]   next_addr
  );
    logic [FD_PAYLOAD_W-1:0] p;
    p = '0;
    p[FD_PC_MSB:FD_PC_LSB]       = pc;
    p[FD_SHMNT_MSB:FD_SHMNT_LSB] = shmnt;
    p[FD_RD_MSB:FD_RD_LSB]       = rd;
    p[FD_RS_MSB:FD_RS_LSB]       = rs;
    p[FD_OPC_MSB:FD_OPC_LSB]     = opcode;
    p[FD_NEXT_MSB:FD_NEXT_LSB]   = next_addr;
    return p;
  endfunction

  function automatic if_id_t fd_unpack(
    input logic [FD_PAYLOAD_W-1:0] p
  );
    return if_id_t'(p);
  endfunction

  function automatic logic [FD_PAYLOAD_W-1:0] fd_nop();
    return fd_pack('0, '0, '0, '0, NOP_OPCODE, '0);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with 2-entry skid and flush.
// Optional stall counter: define PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = FD_PAYLOAD_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] NOP_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_in_ready;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_free;
  logic             w_out_valid_d;
  logic [WIDTH-1:0] w_out_data_d;
  logic             w_skid_valid_d;
  logic [WIDTH-1:0] w_skid_data_d;

  assign w_in_fire   = in_valid & r_in_ready;
  assign w_out_fire  = r_out_valid & out_ready;
  assign w_main_free = ~r_out_valid | w_out_fire;

  always_comb begin
    w_out_valid_d  = r_out_valid;
    w_out_data_d   = r_out_data;
    w_skid_valid_d = r_skid_valid;
    w_skid_data_d  = r_skid_data;
    if (flush) begin
      w_out_valid_d  = 1'b0;
      w_out_data_d   = NOP_VAL;
      w_skid_valid_d = 1'b0;
    end else if (r_skid_valid) begin
      // in_ready is low here, so no new payload can arrive
      if (w_out_fire) begin
        w_out_valid_d  = 1'b1;
        w_out_data_d   = r_skid_data;
        w_skid_valid_d = 1'b0;
      end
    end else if (w_main_free) begin
      w_out_valid_d = w_in_fire;
      if (w_in_fire) begin
        w_out_data_d = in_data;
      end
    end else if (w_in_fire) begin
      w_skid_valid_d = 1'b1;
      w_skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= RESET_VAL;
      r_skid_valid <= 1'b0;
      r_skid_data  <= RESET_VAL;
      r_in_ready   <= 1'b1;
    end else begin
      r_out_valid  <= w_out_valid_d;
      r_out_data   <= w_out_data_d;
      r_skid_valid <= w_skid_valid_d;
      r_skid_data  <= w_skid_data_d;
      r_in_ready   <= ~w_skid_valid_d;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready
                 && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, stall-counter
// sequence (when enabled) and randomized queue-model run.
module tb_pipe_stage_reg;

  localparam int          W   = 80;
  localparam logic [79:0] RV  = 80'h0;
  localparam logic [79:0] NOP = 80'h0000_0000_0000_DEAD_0013;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          flush;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int n_cmp;
  int n_bad;

  pipe_stage_reg #(
    .WIDTH    (W),
    .RESET_VAL(RV),
    .NOP_VAL  (NOP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .flush    (flush)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        flush;
    logic        iv;
    logic [79:0] id;
    logic        ordy;
    logic        eov;
    logic        eir;
    logic [79:0] eod;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic r, input logic f,
                     input logic iv, input logic [79:0] id,
                     input logic ordy, input logic eov,
                     input logic eir, input logic [79:0] eod);
    vec_t v;
    v.name = nm; v.rst_n = r; v.flush = f; v.iv = iv; v.id = id;
    v.ordy = ordy; v.eov = eov; v.eir = eir; v.eod = eod;
    tv.push_back(v);
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [79:0] id, input logic ordy);
    @(negedge clk);
    rst_n = r; flush = f; in_valid = iv; in_data = id;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  logic [79:0] q[$];
  logic [79:0] held;
  logic [95:0] rnd;
  logic        r_iv, r_or, r_fl, fo, fi;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;

    add("rst",     0,0,0,80'h0, 0, 0,1,RV);
    for (int i = 1; i <= 5; i++)
      add($sformatf("stream%0d", i), 1,0,1,80'(i), 1, 1,1,80'(i));
    add("idle",    1,0,0,80'h0, 1, 0,1,80'h5);
    add("stallA",  1,0,1,80'hA, 0, 1,1,80'hA);
    add("skidB",   1,0,1,80'hB, 0, 1,0,80'hA);
    add("blocked", 1,0,1,80'hD, 0, 1,0,80'hA);
    add("relA",    1,0,0,80'h0, 1, 1,1,80'hB);
    add("relB",    1,0,0,80'h0, 1, 0,1,80'hB);
    add("fA",      1,0,1,80'hA, 0, 1,1,80'hA);
    add("fB",      1,0,1,80'hB, 0, 1,0,80'hA);
    add("flush",   1,1,1,80'hC, 0, 0,1,NOP);
    add("postf1",  1,0,0,80'h0, 1, 0,1,NOP);
    add("postf2",  1,0,0,80'h0, 1, 0,1,NOP);
    add("rA",      1,0,1,80'hA, 0, 1,1,80'hA);
    add("rB",      1,0,1,80'hB, 0, 1,0,80'hA);
    add("midrst",  0,0,0,80'h0, 0, 0,1,RV);
    add("p7",      1,0,1,80'h7, 1, 1,1,80'h7);
    add("p7done",  1,0,0,80'h0, 1, 0,1,80'h7);

    foreach (tv[k]) begin
      drive(tv[k].rst_n, tv[k].flush, tv[k].iv, tv[k].id, tv[k].ordy);
      chk({tv[k].name, ".ov"}, 80'(out_valid), 80'(tv[k].eov));
      chk({tv[k].name, ".ir"}, 80'(in_ready), 80'(tv[k].eir));
      chk({tv[k].name, ".od"}, out_data, tv[k].eod);
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    drive(0,0,0,80'h0,0);
    chk("sc.rst", 80'(stall_cnt), 80'h0);
    drive(1,0,1,80'h21,0);
    for (int i = 0; i < 3; i++) drive(1,0,0,80'h0,0);
    chk("sc.three", 80'(stall_cnt), 80'h3);
    drive(1,1,0,80'h0,1);
    chk("sc.flush", 80'(stall_cnt), 80'h3);
    drive(1,0,1,80'h22,0);
    for (int i = 0; i < 65540; i++) drive(1,0,0,80'h0,0);
    chk("sc.sat", 80'(stall_cnt), 80'hFFFF);
    drive(1,0,0,80'h0,0);
    chk("sc.hold", 80'(stall_cnt), 80'hFFFF);
`endif

    drive(0,0,0,80'h0,0);
    q.delete();
    held = RV;
    for (int c = 0; c < 10000; c++) begin
      rnd  = {$urandom(), $urandom(), $urandom()};
      r_iv = ($urandom_range(0, 3) != 0);
      r_or = ($urandom_range(0, 2) != 0);
      r_fl = ($urandom_range(0, 63) == 0);
      if (r_fl) begin
        q.delete();
        held = NOP;
      end else begin
        fo = (q.size() > 0) && r_or;
        fi = r_iv && (q.size() < 2);
        if (fo) void'(q.pop_front());
        if (fi) q.push_back(rnd[79:0]);
        if (q.size() > 0) held = q[0];
      end
      drive(1, r_fl, r_iv, rnd[79:0], r_or);
      chk("rnd.ov", 80'(out_valid), 80'(q.size() > 0));
      chk("rnd.ir", 80'(in_ready), 80'(q.size() < 2));
      chk("rnd.od", out_data, held);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
